// File: rtl/sevenseg_pkg.sv
// Shared constants and the leading-zero blank-mask helper for the digit scanner.
package sevenseg_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned MAX_DIGITS = 32;
    localparam logic        AN_OFF     = 1'b1;
    localparam logic        AN_ON      = 1'b0;

    // Bit k set means digit k is a leading zero: it and every digit above it
    // (below n) carry a zero nibble and a clear dp. Digit 0 is never masked.
    function automatic logic [MAX_DIGITS-1:0] leading_zero_mask(
        input logic [MAX_DIGITS-1:0][DIGIT_W-1:0] d,
        input logic [MAX_DIGITS-1:0]              p,
        input int unsigned                        n
    );
        logic zero_above;
        leading_zero_mask = '0;
        zero_above        = 1'b1;
        for (int unsigned i = MAX_DIGITS - 1; i >= 1; i--) begin
            if (i < n) begin
                zero_above           = zero_above && (d[i] == '0) && !p[i];
                leading_zero_mask[i] = zero_above;
            end
        end
    endfunction

endpackage

// File: rtl/sevenseg_prescaler.sv
// Slot timer: counts clocks within one digit slot and flags the slot end and blank window.
module sevenseg_prescaler #(
    parameter int unsigned CLK_DIV = 1000,
    parameter int unsigned BLANK   = 16
) (
    input  logic clk,
    input  logic rst_n,
    output logic slot_wrap,
    output logic in_blank
);

    localparam int unsigned      CW       = $clog2(CLK_DIV);
    localparam logic [CW-1:0]    CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (slot_wrap) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign slot_wrap = (div_cnt == CNT_LAST);

    generate
        if (BLANK == 0) begin : g_no_blank
            assign in_blank = 1'b0;
        end else begin : g_blank
            localparam logic [CW-1:0] BLANK_L = CW'(BLANK);
            assign in_blank = (div_cnt < BLANK_L);
        end
    endgenerate

endmodule

// File: rtl/sevenseg_scan.sv
// Multiplexed digit scanner: double-buffered value, per-slot anode walk with
// leading blank interval and optional leading-zero suppression.
module sevenseg_scan
    import sevenseg_pkg::*;
#(
    parameter int unsigned DIGITS  = 4,
    parameter int unsigned CLK_DIV = 1000,
    parameter int unsigned BLANK   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DIGIT_W*DIGITS-1:0] digits_in,
    input  logic [DIGITS-1:0]         dp_in,
    input  logic                      load,
    input  logic                      lz_blank,
    output logic [DIGIT_W-1:0]        data,
    output logic                      dp,
    output logic [DIGITS-1:0]         an,
    output logic                      frame_tick
);

    localparam int unsigned   IW       = $clog2(DIGITS);
    localparam int unsigned   MW       = $clog2(MAX_DIGITS);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic                              slot_wrap;
    logic                              in_blank;
    logic                              boundary;
    logic [IW-1:0]                     idx;
    logic [DIGITS-1:0][DIGIT_W-1:0]    staging;
    logic [DIGITS-1:0][DIGIT_W-1:0]    active;
    logic [DIGITS-1:0]                 staging_dp;
    logic [DIGITS-1:0]                 active_dp;
    logic                              pending;
    logic [MAX_DIGITS-1:0][DIGIT_W-1:0] digits_ext;
    logic [MAX_DIGITS-1:0]             dp_ext;
    logic [MAX_DIGITS-1:0]             lz_mask;
    logic [MW-1:0]                     idx_ext;
    logic [DIGITS-1:0]                 an_next;

    sevenseg_prescaler #(
        .CLK_DIV (CLK_DIV),
        .BLANK   (BLANK)
    ) u_prescaler (
        .clk       (clk),
        .rst_n     (rst_n),
        .slot_wrap (slot_wrap),
        .in_blank  (in_blank)
    );

    assign boundary = slot_wrap && (idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (slot_wrap) begin
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
    end

    // A load landing on the boundary edge bypasses staging so it is not
    // held back a whole frame; pending stays clear in that case.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            staging    <= '0;
            staging_dp <= '0;
            active     <= '0;
            active_dp  <= '0;
            pending    <= 1'b0;
        end else begin
            if (load) begin
                staging    <= digits_in;
                staging_dp <= dp_in;
            end
            if (boundary) begin
                pending <= 1'b0;
                if (load) begin
                    active    <= digits_in;
                    active_dp <= dp_in;
                end else if (pending) begin
                    active    <= staging;
                    active_dp <= staging_dp;
                end
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    always_comb begin
        digits_ext              = '0;
        dp_ext                  = '0;
        digits_ext[DIGITS-1:0]  = active;
        dp_ext[DIGITS-1:0]      = active_dp;
        lz_mask                 = leading_zero_mask(digits_ext, dp_ext, DIGITS);
        idx_ext                 = MW'(idx);
    end

    always_comb begin
        an_next = {DIGITS{AN_OFF}};
        if (!in_blank && !(lz_blank && lz_mask[idx_ext])) begin
            an_next[idx] = AN_ON;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an         <= '1;
            data       <= '0;
            dp         <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            an         <= an_next;
            data       <= active[idx];
            dp         <= active_dp[idx];
            frame_tick <= boundary;
        end
    end

endmodule

// File: doc/sevenseg_scan.md
Name: sevenseg_scan

Overview:
Time-multiplexed digit scanner that sits directly upstream of the 4-bit-to-7-segment decoder (sevenseg_top). It holds a multi-digit value and walks through the digits one slot at a time. In each slot it presents one 4-bit nibble on data, plus the matching active-low anode enable. Updates are double-buffered so a frame never tears, and each slot starts with a ghosting-suppression blank interval.

Parameters:
- DIGITS, 4: number of digits/anodes; must be >= 2.
- CLK_DIV, 1000: clock cycles per digit slot; must be > BLANK and >= 2.
- BLANK, 16: cycles at the start of each slot during which all anodes are off; 0 allowed.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- digits_in  in  4*DIGITS  digit k in bits [4k+3:4k]; digit 0 is least significant
- dp_in  in  DIGITS  decimal point per digit
- load  in  1  one-cycle strobe; captures digits_in/dp_in into staging
- lz_blank  in  1  leading-zero blanking enable (sampled live)
- data  out  4  nibble to the 7-seg decoder
- dp  out  1  decimal point of the current digit
- an  out  DIGITS  anode enables, active-low
- frame_tick  out  1  one-cycle pulse at each frame boundary

Behaviour:
Clock and reset:
- Single clock domain, clk. rst_n is asynchronous, active-low.
- Reset (including mid-frame) immediately forces:
  - outputs: an=all 1s, data=0, dp=0, frame_tick=0;
  - internal state: div_cnt=0, idx=0, staging=0, active=0, pending=0.

Counters:
- div_cnt counts 0..CLK_DIV-1 and wraps to 0.
- On each wrap, idx increments 0..DIGITS-1 and wraps to 0.
- A frame boundary is the edge where div_cnt=CLK_DIV-1 and idx=DIGITS-1.

Loading:
- load=1 captures digits_in/dp_in into staging and sets pending.
- At a frame boundary with pending=1: active<=staging, pending<=0.
- load on the boundary edge itself: active<=digits_in/dp_in directly (bypass), staging is updated, pending stays 0.
- Repeated loads within a frame: the last one wins.

Outputs:
- All outputs are registered and lag (div_cnt, idx) by exactly one clock.
- an: all 1s when div_cnt < BLANK or the digit is blanked; otherwise only bit idx is 0.
- data = active nibble idx; dp = active dp idx. Both are driven regardless of blanking.
- Leading-zero blanking, when lz_blank=1: digit k>0 is blanked if it and every higher digit are 0 and their dp bits are 0. Digit 0 is never blanked.
- Nibbles 10..15 pass through unmodified.
- frame_tick=1 for exactly the one clock following the boundary edge.

Arithmetic:
- div_cnt width is clog2(CLK_DIV); idx width is clog2(DIGITS).
- No wider intermediate values; comparisons are unsigned.

Decomposition:
- Package sevenseg_pkg:
  - DIGIT_W=4;
  - AN_OFF=1'b1 and AN_ON=1'b0;
  - a function that computes the blank mask from active data and dp.
- One sub-module, sevenseg_prescaler:
  - contains div_cnt;
  - outputs slot_wrap (div_cnt==CLK_DIV-1) and in_blank (div_cnt<BLANK).
- Top level holds idx, the staging/active registers and the output registers.

Test Plan:
1. Setup for scenarios 1-4: DIGITS=4, CLK_DIV=8, BLANK=2, load 0x4321 at reset release, lz_blank=0.
   - After edges 1-2: an=1111.
   - After edges 3-8: an=1110, data=0 (active not yet loaded).
   - frame_tick high only after edge 32.
   - After edge 35: an=1110, data=1. After edge 43: an=1101, data=2.
2. Load 0x00A7 mid-frame, then 0x0005 two cycles later.
   - Current frame keeps showing the old value.
   - Next frame shows only 0x0005; 0x00A7 is never displayed.
   - data=0xA is not remapped when shown.
3. lz_blank=1, active=0x0050.
   - Digits 3 and 2: an=1111 for the whole slot.
   - Digit 1: an=1101, data=5. Digit 0: an=1110, data=0.
   - Variant: set dp_in[3]=1; digit 3 is now displayed with data=0.
4. Pulse load exactly on the frame-boundary edge with 0x9999.
   - The very next frame shows 9 on every digit; pending reads 0 afterwards.
5. Assert rst_n low asynchronously mid-slot (between clock edges).
   - an=1111 and frame_tick=0 immediately, before any edge.
   - After release, the edge-1..8 timing of scenario 1 repeats exactly.
6. BLANK=0, CLK_DIV=2, DIGITS=2.
   - an alternates 10, 01 every two cycles with no all-off gap.
   - frame_tick pulses every 4 clocks.
